// File: rtl/tt_capture.sv
// ---------------------------------------------------------------------------
// tt_capture -- sequential truth-table extractor for a 7-input, single-output
// combinational (or pipelined) function block.
//
// The module sweeps every input assignment 0..2**N_IN-1 on x_drv, one per
// clock. It collects the block's response on f_in into the truth table tt,
// then compares the table with a reference latched at start.
//
// Parameters
//   N_IN     number of function inputs (table width 2**N_IN); fixed at 7
//   LATENCY  cycles from driving x_drv to the matching f_in (0..7)
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous, active-high reset
//   start     one-cycle request to begin a sweep (ignored unless idle)
//   expected  reference truth table, latched on an accepted start
//   x_drv     assignment driven to the block; x_drv[0] drives x0
//   f_in      block output for the assignment driven LATENCY cycles earlier
//   busy      high while sweeping or draining the block's pipeline
//   done      one-cycle pulse when the table is complete
//   tt        captured truth table, bit i = f(i)
//   match     tt == latched expected; valid from the done cycle on
//   ones_cnt  popcount of tt (present only with TT_CAPTURE_ONES_EN)
//
// Build option
//   TT_CAPTURE_ONES_EN  when defined, adds the ones_cnt output. It is
//                       accumulated one captured f_in at a time.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tt_capture #(
  parameter int N_IN    = 7,
  parameter int LATENCY = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [(1<<N_IN)-1:0]    expected,
  output logic [N_IN-1:0]         x_drv,
  input  logic                    f_in,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<N_IN)-1:0]    tt,
  output logic                    match
`ifdef TT_CAPTURE_ONES_EN
  ,
  output logic [7:0]              ones_cnt
`endif
);

  localparam int TW = 1 << N_IN;
  localparam int KW = 8;

  // Cycle index (since SWEEP entry) of the last busy cycle. The final
  // capture happens on the edge that ends this cycle.
  localparam logic [KW-1:0]   K_LAST = KW'(TW - 1 + LATENCY);
  localparam logic [KW-1:0]   LAT_K  = KW'(LATENCY);
  localparam logic [N_IN-1:0] D_MAX  = {N_IN{1'b1}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]      state;
  logic [KW-1:0]   k;          // cycles since SWEEP entry
  logic [N_IN-1:0] d;          // drive counter, saturates at D_MAX
  logic [TW-1:0]   exp_lat;
  logic            sweeping;
  logic            cap_en;
  logic [N_IN-1:0] cap_idx;
  logic [TW-1:0]   tt_next;

  // Saturating increment: the drive counter must hold at the last
  // assignment instead of wrapping back to 0 during the drain.
  function automatic logic [N_IN-1:0] sat_inc(input logic [N_IN-1:0] v);
    if (v == D_MAX) begin
      return v;
    end
    return v + {{(N_IN-1){1'b0}}, 1'b1};
  endfunction

  assign sweeping = (state == S_SWEEP) || (state == S_DRAIN);
  assign busy     = sweeping;
  assign done     = (state == S_FIN);
  assign x_drv    = d;

  // f_in lags x_drv by LATENCY cycles, so the capture index trails the
  // cycle count. Every busy cycle with k >= LATENCY carries a valid
  // response.
  generate
    if (LATENCY == 0) begin : g_cap_comb
      assign cap_en = sweeping;
    end else begin : g_cap_lat
      assign cap_en = sweeping && (k >= LAT_K);
    end
  endgenerate

  assign cap_idx = N_IN'(k - LAT_K);

  always_comb begin
    tt_next = tt;
    if (cap_en) begin
      tt_next[cap_idx] = f_in;
    end
  end

  // ---- control + capture register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      k       <= '0;
      d       <= '0;
      exp_lat <= '0;
      tt      <= '0;
      match   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_SWEEP;
            exp_lat <= expected;
            tt      <= '0;
            match   <= 1'b0;
            k       <= '0;
            d       <= '0;
          end
        end
        S_SWEEP, S_DRAIN: begin
          tt <= tt_next;
          k  <= k + KW'(1);
          if (k == K_LAST) begin
            // Final capture lands on this edge, so the compare uses the
            // updated table to make match valid together with done.
            state <= S_FIN;
            match <= (tt_next == exp_lat);
            d     <= '0;
          end else if (state == S_SWEEP) begin
            // Reaching D_MAX here before K_LAST implies LATENCY > 0.
            if (d == D_MAX) begin
              state <= S_DRAIN;
            end
            d <= sat_inc(d);
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef TT_CAPTURE_ONES_EN
  // ---- popcount accumulator stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if ((state == S_IDLE) && start) begin
      ones_cnt <= '0;
    end else if (cap_en && f_in) begin
      ones_cnt <= ones_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tt_capture.sv
`timescale 1ns/1ps

module tb_tt_capture;

  localparam logic [127:0] MAJ = 128'hfeeaeae8eea8aaa0faaaea88e8a8a880;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start    [2];
  logic [127:0] expected [2];
  logic [6:0]   x_drv    [2];
  logic         f_in     [2];
  logic         busy     [2];
  logic         done     [2];
  logic [127:0] tt       [2];
  logic         match    [2];
`ifdef TT_CAPTURE_ONES_EN
  logic [7:0]   ones     [2];
`endif

  // Function under test for each instance, stored as its truth table.
  logic [127:0] ftbl [2];
  logic [6:0]   xq   [3] = '{default: 7'd0};

  assign f_in[0] = ftbl[0][x_drv[0]];
  always @(posedge clk) begin
    xq[0] <= x_drv[1];
    xq[1] <= xq[0];
    xq[2] <= xq[1];
  end
  assign f_in[1] = ftbl[1][xq[2]];

  tt_capture #(.N_IN(7), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .start(start[0]), .expected(expected[0]),
    .x_drv(x_drv[0]), .f_in(f_in[0]), .busy(busy[0]), .done(done[0]),
    .tt(tt[0]), .match(match[0])
`ifdef TT_CAPTURE_ONES_EN
    , .ones_cnt(ones[0])
`endif
  );

  tt_capture #(.N_IN(7), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .start(start[1]), .expected(expected[1]),
    .x_drv(x_drv[1]), .f_in(f_in[1]), .busy(busy[1]), .done(done[1]),
    .tt(tt[1]), .match(match[1])
`ifdef TT_CAPTURE_ONES_EN
    , .ones_cnt(ones[1])
`endif
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int s, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h at %0t", nm, s, a, e, $time);
    end
  endtask

  function automatic int lat(input int s);
    return (s == 0) ? 0 : 3;
  endfunction

  // Behavioural model. ph = cycles since the accepted start edge
  // (-1 when idle). The done cycle is 128+L. Results are the function's
  // table, its popcount, and equality with the latched reference.
  int           ph      [2] = '{-1, -1};
  logic [127:0] m_exp   [2] = '{default: '0};
  logic [127:0] m_tt    [2] = '{default: '0};
  logic         m_match [2] = '{default: 1'b0};
  int           m_ones  [2] = '{0, 0};

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        ph[s]      <= -1;
        m_exp[s]   <= '0;
        m_tt[s]    <= '0;
        m_match[s] <= 1'b0;
        m_ones[s]  <= 0;
      end else if (ph[s] < 0) begin
        if (start[s]) begin
          ph[s]      <= 0;
          m_exp[s]   <= expected[s];
          m_tt[s]    <= '0;
          m_match[s] <= 1'b0;
          m_ones[s]  <= 0;
        end
      end else if (ph[s] == 128 + lat(s)) begin
        ph[s] <= -1;
      end else begin
        ph[s] <= ph[s] + 1;
        if (ph[s] + 1 == 128 + lat(s)) begin
          m_tt[s]    <= ftbl[s];
          m_match[s] <= (ftbl[s] == m_exp[s]);
          m_ones[s]  <= $countones(ftbl[s]);
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        int p;
        int xe;
        p = ph[s];
        if (p >= 0 && p <= 127)             xe = p;
        else if (p > 127 && p < 128+lat(s)) xe = 127;
        else                                xe = 0;
        chk("busy",  s, busy[s], (p >= 0 && p < 128 + lat(s)));
        chk("done",  s, done[s], (p == 128 + lat(s)));
        chk("x_drv", s, x_drv[s], xe);
        if (p < 0 || p == 128 + lat(s)) begin
          chk("tt",    s, tt[s], m_tt[s]);
          chk("match", s, match[s], m_match[s]);
`ifdef TT_CAPTURE_ONES_EN
          chk("ones",  s, ones[s], m_ones[s]);
`endif
        end else begin
          chk("match_busy", s, match[s], 1'b0);
        end
      end
    end
  end

  task automatic run(input int s, input logic [127:0] t, input logic [127:0] e, output int n);
    @(negedge clk);
    ftbl[s]     = t;
    expected[s] = e;
    start[s]    = 1'b1;
    @(negedge clk);
    start[s]    = 1'b0;
    expected[s] = ~e;
    n = 0;
    while (done[s] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [127:0] t;
    logic [127:0] e;
    int n;
    int dcnt;

    start    = '{1'b0, 1'b0};
    expected = '{128'd0, 128'd0};
    ftbl     = '{128'd0, 128'd0};
    rst      = 1'b1;
    repeat (3) @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      chk("rst_x_drv", s, x_drv[s], 0);
      chk("rst_busy",  s, busy[s], 0);
      chk("rst_done",  s, done[s], 0);
      chk("rst_tt",    s, tt[s], 0);
      chk("rst_match", s, match[s], 0);
`ifdef TT_CAPTURE_ONES_EN
      chk("rst_ones",  s, ones[s], 0);
`endif
    end
    rst    = 1'b0;
    chk_en = 1'b1;

    // f = x0, LATENCY 0
    for (int i = 0; i < 128; i++) t[i] = i[0];
    chk("pin_x0_tbl", 0, t, 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa);
    run(0, t, t, n);
    chk("x0_done_cyc", 0, n, 128);
    chk("x0_tt",    0, tt[0], 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa);
    chk("x0_match", 0, match[0], 1'b1);
`ifdef TT_CAPTURE_ONES_EN
    chk("x0_ones",  0, ones[0], 64);
`endif

    // majority network, back-to-back start
    run(0, MAJ, MAJ, n);
    chk("maj_done_cyc", 0, n, 128);
    chk("maj_tt",    0, tt[0], MAJ);
    chk("maj_match", 0, match[0], 1'b1);

    // same network, expected bit 5 flipped
    run(0, MAJ, MAJ ^ 128'h20, n);
    chk("majx_tt",    0, tt[0], MAJ);
    chk("majx_match", 0, match[0], 1'b0);

    // 7-input AND through a 3-stage pipeline
    for (int i = 0; i < 128; i++) t[i] = (i == 127);
    chk("pin_and_tbl", 1, t, 128'h80000000000000000000000000000000);
    run(1, t, t, n);
    chk("and_done_cyc", 1, n, 131);
    chk("and_tt",    1, tt[1], 128'h80000000000000000000000000000000);
    chk("and_match", 1, match[1], 1'b1);
`ifdef TT_CAPTURE_ONES_EN
    chk("and_ones",  1, ones[1], 1);
`endif

    // reset at sweep cycle 40, start coincident with rst
    @(negedge clk);
    ftbl[0]     = {$urandom, $urandom, $urandom, $urandom};
    expected[0] = '0;
    start[0]    = 1'b1;
    @(negedge clk);
    start[0]    = 1'b0;
    repeat (39) @(negedge clk);
    rst      = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    start[0] = 1'b0;
    chk("mid_rst_busy", 0, busy[0], 1'b0);
    chk("mid_rst_tt",   0, tt[0], 128'd0);
    repeat (3) @(negedge clk);
    chk("rst_start_idle", 0, busy[0], 1'b0);
    run(0, {128{1'b1}}, {128{1'b1}}, n);
    chk("ones_done_cyc", 0, n, 128);
    chk("ones_tt",    0, tt[0], 128'hffffffffffffffffffffffffffffffff);
    chk("ones_match", 0, match[0], 1'b1);
`ifdef TT_CAPTURE_ONES_EN
    chk("ones_cnt128", 0, ones[0], 128);
`endif

    // start held through most of the sweep, extra pulse during drain
    @(negedge clk);
    ftbl[1]     = '0;
    expected[1] = '0;
    start[1]    = 1'b1;
    @(negedge clk);
    expected[1] = {128{1'b1}};
    repeat (125) @(negedge clk);
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    n = 129;
    while (done[1] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("hold_done_cyc", 1, n, 131);
    chk("hold_tt",    1, tt[1], 128'd0);
    chk("hold_match", 1, match[1], 1'b1);
    dcnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done[1] === 1'b1) dcnt++;
    end
    chk("hold_extra_done", 1, dcnt, 0);

    // randomized tables on both instances
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < 2; s++) begin
        t = {$urandom, $urandom, $urandom, $urandom};
        e = (r % 2 == 1) ? t : (t ^ (128'd1 << $urandom_range(127, 0)));
        run(s, t, e, n);
        chk("rnd_done_cyc", s, n, 128 + lat(s));
        chk("rnd_tt",    s, tt[s], t);
        chk("rnd_match", s, match[s], (r % 2 == 1));
      end
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
